microwave_timer: RTL

Countdown timer for the microwave oven. It holds the cook time as four BCD digits (MM:SS) entered from the keypad, counts down one second per `TICKS_PER_SEC` clocks while the magnetron is on, and reports completion. It sits on the other side of the control path: it consumes `mag_on` from the on/off controller and produces the `timer_done` that controller consumes to drop the magnetron. Its digit outputs drive the display decoder.

---
 rtl/microwave_timer_if.sv | 25 ++
 rtl/microwave_timer.sv | 127 ++++++++++++
 2 files changed

// File: rtl/microwave_timer_if.sv
// Keypad/controller/display bundle for the microwave countdown timer.
// The master side (controller, keypad, bench) drives the buttons and mag_on.
// The slave side (the timer) returns the BCD time and completion flags.
interface microwave_timer_if;
   logic       clearn;
   logic       load_digit;
   logic [3:0] digit;
   logic       mag_on;
   logic [3:0] min_tens;
   logic [3:0] min_ones;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic       timer_done;
   logic       done_pulse;

   modport master (
      output clearn, load_digit, digit, mag_on,
      input  min_tens, min_ones, sec_tens, sec_ones, timer_done, done_pulse
   );

   modport slave (
      input  clearn, load_digit, digit, mag_on,
      output min_tens, min_ones, sec_tens, sec_ones, timer_done, done_pulse
   );
endinterface

// File: rtl/microwave_timer.sv
// Microwave cook-time countdown: MM:SS held as four BCD digits, keypad entry
// by left shift, one-second decrement per TICKS_PER_SEC clocks while the
// magnetron is on, and a done level/pulse for the on/off controller.
module microwave_timer #(
   parameter int TICKS_PER_SEC = 100
) (
   input logic            clk,
   input logic            rst,
   microwave_timer_if.slave bus
);

   localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SET  = 2'd1,
      RUN  = 2'd2
   } state_t;

   // Time packed as {min_tens, min_ones, sec_tens, sec_ones}.
   logic [15:0]   cur_time;
   logic [15:0]   nxt_time;
   logic [PW-1:0] pre;
   logic [PW-1:0] nxt_pre;
   state_t        state;
   state_t        nxt_state;
   logic          nxt_pulse;
   logic          done;
   logic          pulse;

   // One-second BCD decrement with the MM:SS borrow chain; sec_tens above 5
   // simply counts down like any other digit.
   function automatic logic [15:0] bcd_dec(input logic [15:0] t);
      logic [3:0] mt, mo, st, so;
      mt = t[15:12];
      mo = t[11:8];
      st = t[7:4];
      so = t[3:0];
      if (so != 4'd0) begin
         so = so - 4'd1;
      end else begin
         so = 4'd9;
         if (st != 4'd0) begin
            st = st - 4'd1;
         end else begin
            st = 4'd5;
            if (mo != 4'd0) begin
               mo = mo - 4'd1;
            end else begin
               mo = 4'd9;
               mt = mt - 4'd1;
            end
         end
      end
      return {mt, mo, st, so};
   endfunction

   // Next time/prescaler/pulse: clear beats load, load beats countdown.
   always_comb begin
      nxt_time  = cur_time;
      nxt_pre   = pre;
      nxt_pulse = 1'b0;
      if (!bus.clearn) begin
         nxt_time = 16'h0000;
         nxt_pre  = '0;
      end else if (bus.load_digit && !bus.mag_on && (bus.digit <= 4'd9)) begin
         nxt_time = {cur_time[11:0], bus.digit};
         nxt_pre  = '0;
      end else if (bus.mag_on && (state != IDLE)) begin
         if (pre == PRE_LAST) begin
            nxt_pre  = '0;
            nxt_time = bcd_dec(cur_time);
            if (bcd_dec(cur_time) == 16'h0000) begin
               nxt_pulse = 1'b1;
            end else begin
               nxt_pulse = 1'b0;
            end
         end else begin
            nxt_pre = pre + PW'(1);
         end
      end else begin
         nxt_time = cur_time;
      end
   end

   // State follows the time being registered on the same edge.
   always_comb begin
      if (nxt_time == 16'h0000) begin
         nxt_state = IDLE;
      end else if (bus.mag_on) begin
         nxt_state = RUN;
      end else begin
         nxt_state = SET;
      end
   end

   // Register time, prescaler, state and both completion outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_time <= 16'h0000;
         pre      <= '0;
         state    <= IDLE;
         done     <= 1'b1;
         pulse    <= 1'b0;
      end else begin
         cur_time <= nxt_time;
         pre      <= nxt_pre;
         pulse    <= nxt_pulse;
         done     <= (nxt_time == 16'h0000);
         case (nxt_state)
            IDLE:    state <= IDLE;
            SET:     state <= SET;
            RUN:     state <= RUN;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.min_tens   = cur_time[15:12];
   assign bus.min_ones   = cur_time[11:8];
   assign bus.sec_tens   = cur_time[7:4];
   assign bus.sec_ones   = cur_time[3:0];
   assign bus.timer_done = done;
   assign bus.done_pulse = pulse;

endmodule
